// File: rtl/tx_frame_sequencer_pkg.sv
// tx_frame_sequencer_pkg: shared encodings and helpers for the transmit frame sequencer.
package tx_frame_sequencer_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;
    typedef enum logic {
        CLS_H = 1'b0,
        CLS_L = 1'b1
    } class_e;
    localparam logic [1:0] P_BE  = 2'd0;
    localparam logic [1:0] P_RC  = 2'd1;
    localparam logic [1:0] P_TT  = 2'd2;
    localparam logic [1:0] P_PCF = 2'd3;
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/tx_frame_sequencer_grant_select.sv
// grant_select: combinational priority pick of go pulses, H first then lowest L index.
module grant_select
    import tx_frame_sequencer_pkg::*;
#(
    parameter int N_L = 3
) (
    input  logic           go_h_i,
    input  logic [N_L-1:0] go_l_i,
    output logic           valid_o,
    output class_e         class_o,
    output logic [2:0]     idx_o,
    output logic           multi_o
);
    logic [N_L:0] all_go;
    logic [2:0]   l_idx;
    assign all_go = {go_l_i, go_h_i};
    always_comb begin
        l_idx = '0;
        for (int i = N_L - 1; i >= 0; i--) l_idx = go_l_i[i] ? 3'(i) : l_idx;
        valid_o = |all_go;
        class_o = go_h_i ? CLS_H : CLS_L;
        idx_o   = go_h_i ? 3'd0 : l_idx;
        // clearing the lowest set bit leaves something only when two or more are set
        multi_o = |(all_go & (all_go - (N_L+1)'(1)));
    end
endmodule

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: plays granted frames as tx_en bursts plus inter-frame gap,
// with busy feedback to the scheduler, per-class frame counters and sticky errors.
module tx_frame_sequencer
    import tx_frame_sequencer_pkg::*;
#(
    parameter int N_L        = 3,
    parameter int IFG_CYCLES = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go_H_i,
    input  logic [N_L-1:0]   go_L_i,
    input  logic [7:0]       pkt_len_H_i,
    input  logic [8*N_L-1:0] pkt_len_L_i,
    output logic             ena_n_o,
    output logic             tx_en_o,
    output logic             tx_class_o,
    output logic [2:0]       tx_channel_o,
    output logic [7:0]       tx_remaining_o,
    output logic             tx_done_o,
    output logic [15:0]      cnt_H_o,
    output logic [15:0]      cnt_L_o,
    output logic             err_conflict_o,
    output logic             err_overrun_o,
    output logic             err_zero_len_o
);
    localparam logic [7:0] IFG = 8'(IFG_CYCLES);

    state_e      state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    logic [7:0]  gap_q, gap_d;
    class_e      cls_q, cls_d;
    logic [2:0]  chan_q, chan_d;
    logic [15:0] cnt_h_q, cnt_h_d;
    logic [15:0] cnt_l_q, cnt_l_d;
    logic        conf_q, conf_d;
    logic        over_q, over_d;
    logic        zero_q, zero_d;

    logic        win_valid;
    class_e      win_cls;
    logic [2:0]  win_idx;
    logic        win_multi;
    logic [7:0]  win_len;
    logic        idle;

    grant_select #(.N_L(N_L)) u_grant_select (
        .go_h_i  (go_H_i),
        .go_l_i  (go_L_i),
        .valid_o (win_valid),
        .class_o (win_cls),
        .idx_o   (win_idx),
        .multi_o (win_multi)
    );

    always_comb begin
        win_len = pkt_len_H_i;
        for (int i = 0; i < N_L; i++)
            win_len = (win_cls == CLS_L && win_idx == 3'(i)) ? pkt_len_L_i[8*i +: 8] : win_len;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            gap_q   <= '0;
            cls_q   <= CLS_H;
            chan_q  <= '0;
            cnt_h_q <= '0;
            cnt_l_q <= '0;
            conf_q  <= 1'b0;
            over_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            cls_q   <= cls_d;
            chan_q  <= chan_d;
            cnt_h_q <= cnt_h_d;
            cnt_l_q <= cnt_l_d;
            conf_q  <= conf_d;
            over_q  <= over_d;
            zero_q  <= zero_d;
        end
    end

    assign idle = (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        cls_d   = cls_q;
        chan_d  = chan_q;
        cnt_h_d = cnt_h_q;
        cnt_l_d = cnt_l_q;
        conf_d  = conf_q | win_multi;
        over_d  = over_q | (win_valid && !idle);
        zero_d  = zero_q | (win_valid && idle && win_len == 8'd0);
        if (idle && win_valid && win_len != 8'd0) begin
            state_d = ST_SEND;
            rem_d   = win_len;
            cls_d   = win_cls;
            chan_d  = win_idx;
        end else if (state_q == ST_SEND) begin
            state_d = (rem_q == 8'd1) ? ST_GAP : ST_SEND;
            rem_d   = (rem_q == 8'd1) ? 8'd0 : rem_q - 8'd1;
            gap_d   = (rem_q == 8'd1) ? IFG : gap_q;
            cnt_h_d = (rem_q == 8'd1 && cls_q == CLS_H) ? sat_inc(cnt_h_q) : cnt_h_q;
            cnt_l_d = (rem_q == 8'd1 && cls_q == CLS_L) ? sat_inc(cnt_l_q) : cnt_l_q;
        end else if (state_q == ST_GAP) begin
            state_d = (gap_q == 8'd1) ? ST_IDLE : ST_GAP;
            gap_d   = (gap_q == 8'd1) ? 8'd0 : gap_q - 8'd1;
        end
    end

    always_comb begin
        ena_n_o        = !idle;
        tx_en_o        = (state_q == ST_SEND);
        tx_done_o      = (state_q == ST_SEND) && (rem_q == 8'd1);
        tx_class_o     = cls_q;
        tx_channel_o   = chan_q;
        tx_remaining_o = rem_q;
        cnt_H_o        = cnt_h_q;
        cnt_L_o        = cnt_l_q;
        err_conflict_o = conf_q;
        err_overrun_o  = over_q;
        err_zero_len_o = zero_q;
    end
endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb_tx_frame_sequencer: scoreboard bench with a cycle-timeline reference model.
module tb_tx_frame_sequencer;
    localparam int N_L = 3;
    localparam int IFG = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             go_H;
    logic [N_L-1:0]   go_L;
    logic [7:0]       pkt_len_H;
    logic [8*N_L-1:0] pkt_len_L;
    logic             ena_n, tx_en, tx_class, tx_done;
    logic [2:0]       tx_channel;
    logic [7:0]       tx_remaining;
    logic [15:0]      cnt_H, cnt_L;
    logic             err_conflict, err_overrun, err_zero_len;

    tx_frame_sequencer #(.N_L(N_L), .IFG_CYCLES(IFG)) dut (
        .clk            (clk),
        .rst            (rst),
        .go_H_i         (go_H),
        .go_L_i         (go_L),
        .pkt_len_H_i    (pkt_len_H),
        .pkt_len_L_i    (pkt_len_L),
        .ena_n_o        (ena_n),
        .tx_en_o        (tx_en),
        .tx_class_o     (tx_class),
        .tx_channel_o   (tx_channel),
        .tx_remaining_o (tx_remaining),
        .tx_done_o      (tx_done),
        .cnt_H_o        (cnt_H),
        .cnt_L_o        (cnt_L),
        .err_conflict_o (err_conflict),
        .err_overrun_o  (err_overrun),
        .err_zero_len_o (err_zero_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit cls;
        int ch;
        int len;
        int start;
    } frame_t;

    frame_t exp_q[$];
    frame_t cur;
    int     cur_left = 0;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     free_c = 0;
    int     m_cnt_h = 0, m_cnt_l = 0;
    bit     m_conf = 0, m_over = 0, m_zero = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one stimulus cycle: check port-busy against the timeline, drive inputs, advance model
    task automatic issue(input logic h, input logic [N_L-1:0] l, input logic [7:0] lh,
                         input logic [8*N_L-1:0] ll);
        int c, n, len, ch;
        @(posedge clk);
        #1;
        c = cyc;
        check("ena_n", int'(ena_n), (c < free_c) ? 1 : 0);
        go_H = h;
        go_L = l;
        pkt_len_H = lh;
        pkt_len_L = ll;
        n = int'(h) + $countones(l);
        if (n > 1) m_conf = 1;
        if (n > 0) begin
            if (c < free_c) m_over = 1;
            else begin
                ch = 0;
                len = int'(lh);
                if (!h)
                    for (int i = 0; i < N_L; i++)
                        if (l[i]) begin
                            ch = i;
                            len = int'(ll[8*i +: 8]);
                            break;
                        end
                if (len == 0) m_zero = 1;
                else begin
                    exp_q.push_back('{!h, ch, len, c + 1});
                    free_c = c + 1 + len + IFG;
                    if (h) m_cnt_h = (m_cnt_h < 65535) ? m_cnt_h + 1 : m_cnt_h;
                    else m_cnt_l = (m_cnt_l < 65535) ? m_cnt_l + 1 : m_cnt_l;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, '0, 8'($urandom), (8*N_L)'($urandom));
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cnt_H"}, int'(cnt_H), m_cnt_h);
        check({tag, "_cnt_L"}, int'(cnt_L), m_cnt_l);
        check({tag, "_err_conflict"}, int'(err_conflict), int'(m_conf));
        check({tag, "_err_overrun"}, int'(err_overrun), int'(m_over));
        check({tag, "_err_zero_len"}, int'(err_zero_len), int'(m_zero));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || cyc < free_c) && n < 1000) begin
            idle(1);
            n++;
        end
        if (n >= 1000) check({tag, "_drain_timeout"}, 1, 0);
        idle(1);
        check_state(tag);
    endtask

    function automatic logic [8*N_L-1:0] lens(input int l0, input int l1, input int l2);
        logic [8*N_L-1:0] v;
        v = {8'(l2), 8'(l1), 8'(l0)};
        return v;
    endfunction

    function automatic logic [7:0] rlen();
        return ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
    endfunction

    always @(negedge clk) begin
        if (rst) cur_left = 0;
        else if (tx_en) begin
            if (cur_left == 0) begin
                if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
                else begin
                    cur = exp_q.pop_front();
                    cur_left = cur.len;
                    check("frame_start_cycle", cyc, cur.start);
                end
            end
            if (cur_left > 0) begin
                check("tx_class", int'(tx_class), int'(cur.cls));
                check("tx_channel", int'(tx_channel), cur.ch);
                check("tx_remaining", int'(tx_remaining), cur_left);
                check("tx_done", int'(tx_done), (cur_left == 1) ? 1 : 0);
                cur_left--;
            end
        end else if (cur_left > 0) begin
            check("tx_en_truncated", 0, 1);
            cur_left = 0;
        end else check("tx_done_outside_frame", int'(tx_done), 0);
    end

    initial begin
        rst = 1'b1;
        go_H = 1'b0;
        go_L = '0;
        pkt_len_H = '0;
        pkt_len_L = '0;
        #1;
        check("rst_ena_n", int'(ena_n), 0);
        check("rst_tx_en", int'(tx_en), 0);
        check("rst_tx_class", int'(tx_class), 0);
        check("rst_tx_channel", int'(tx_channel), 0);
        check("rst_tx_remaining", int'(tx_remaining), 0);
        check("rst_tx_done", int'(tx_done), 0);
        check_state("rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        issue(1'b1, '0, 8'd4, lens(7, 7, 7));
        drain("single_h");
        issue(1'b0, 3'b100, 8'd9, lens(3, 3, 8));
        drain("l2_len8");
        issue(1'b1, 3'b001, 8'd3, lens(5, 6, 6));
        drain("conflict");
        issue(1'b0, 3'b010, 8'd0, lens(0, 6, 0));
        idle(9);
        issue(1'b0, 3'b010, 8'd0, lens(0, 6, 0));
        drain("overrun_gap");
        issue(1'b1, '0, 8'd0, lens(4, 4, 4));
        idle(1);
        issue(1'b1, '0, 8'd2, lens(4, 4, 4));
        drain("zero_len");
        issue(1'b0, 3'b001, 8'd1, lens(255, 1, 1));
        drain("len255");
        issue(1'b0, 3'b110, 8'd1, lens(1, 2, 3));
        drain("l_priority");

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 99) < 30)
                issue(1'($urandom_range(0, 3) == 0), N_L'($urandom_range(1, 7)), rlen(),
                      {rlen(), rlen(), rlen()});
            else idle(1);
        end
        drain("random");

        issue(1'b1, '0, 8'd10, lens(1, 1, 1));
        idle(2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        free_c = 0;
        m_cnt_h = 0;
        m_cnt_l = 0;
        m_conf = 0;
        m_over = 0;
        m_zero = 0;
        #1;
        check("midrst_tx_en", int'(tx_en), 0);
        check("midrst_ena_n", int'(ena_n), 0);
        check("midrst_tx_remaining", int'(tx_remaining), 0);
        check_state("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1'b1, '0, 8'd1, lens(9, 9, 9));
        drain("after_rst_len1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
